uartcon_tx: RTL and testbench

UARTCON_TX -- requirements
Module: uartcon_tx

---
 rtl/uartcon_tx.sv | 165 ++++++++++++++++
 tb/tb_uartcon_tx.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uartcon_tx.sv
// uartcon_tx: byte-wide UART transmitter with a small write FIFO.
// Bytes are queued through a valid/ready handshake and sent as 8N1 frames,
// LSB first, each bit lasting CLKS_PER_BIT clocks. Frames queued behind one
// another go out back-to-back with no idle time between stop and start.
// The pin is driven from a register that trails the FSM state by one clock,
// so busy also covers the final stop bit still leaving through that register.

module uartcon_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    output logic       ready,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [CW-1:0]  bit_cnt;
    logic           bit_end;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;

    logic [7:0]     mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    logic           txd_next;
    logic           line_active;

    // The extra pointer MSB tells a full FIFO (same slot, different lap) from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign ready   = !full;
    assign push    = valid && !full;
    assign bit_end = (bit_cnt == CW'(CLKS_PER_BIT - 1));
    assign busy    = (state != IDLE) || !empty || line_active;

    // FIFO storage; only written on an accepted byte, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= data;
        end
    end

    // State register plus FIFO pointers, bit timing and the shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state <= state_next;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (state == IDLE || bit_end) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (pop) begin
                shreg <= mem[rd_ptr[FIFO_AW-1:0]];
            end else if (state == DATA && bit_end) begin
                shreg <= shreg >> 1;
            end
        end
    end

    // Next-state logic; a pop happens only when launching a frame from a non-empty FIFO.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line level implied by the current state, registered below onto the pin.
    always_comb begin
        txd_next = 1'b1;
        unique case (state)
            IDLE:    txd_next = 1'b1;
            START:   txd_next = 1'b0;
            DATA:    txd_next = shreg[0];
            STOP:    txd_next = 1'b1;
            default: txd_next = 1'b1;
        endcase
    end

    // Output register: pin level and a flag marking that a frame bit is still on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd         <= 1'b1;
            line_active <= 1'b0;
        end else begin
            txd         <= txd_next;
            line_active <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_uartcon_tx.sv
// Testbench for uartcon_tx: table-driven single-frame vectors plus directed
// sequences for latency, back-to-back frames, FIFO full, push/pop at the frame
// boundary, mid-frame reset and a 256-byte loopback through a receiver model.

module tb_uartcon_tx;

    localparam int CPB = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       txd;
    logic       busy;

    int n_compared = 0;
    int n_failed   = 0;
    int cyc        = 0;

    // Receiver model state
    logic [7:0] rx_q [$];
    int         start_q [$];
    int         frame_err = 0;
    int         m_state = 0;
    int         m_cnt = 0;
    int         m_start = 0;
    int         m_k = 0;
    logic [7:0] m_bits = 8'h00;

    typedef struct {
        logic [7:0] din;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [6];

    uartcon_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_AW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid(valid),
        .ready(ready),
        .data(data),
        .txd(txd),
        .busy(busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Free-running edge counter used to time stamp start bits
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: samples the line mid-bit on falling edges and queues decoded bytes
    always @(negedge clk) begin
        if (rst) begin
            m_state = 0;
            m_cnt   = 0;
        end else if (m_state == 0) begin
            if (txd === 1'b0) begin
                m_state = 1;
                m_cnt   = 0;
                m_start = cyc;
            end
        end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == CPB / 2) begin
                if (txd !== 1'b0) m_state = 0;
            end else if (m_cnt > CPB / 2 && ((m_cnt - CPB / 2) % CPB) == 0) begin
                m_k = (m_cnt - CPB / 2) / CPB;
                if (m_k <= 8) begin
                    m_bits[m_k - 1] = txd;
                end else begin
                    if (txd !== 1'b1) frame_err = frame_err + 1;
                    rx_q.push_back(m_bits);
                    start_q.push_back(m_start);
                    m_state = 0;
                end
            end
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one byte for one clock; took reports whether the FIFO could accept it
    task automatic applyStimulus(input logic [7:0] d, output logic took);
        @(negedge clk);
        valid = 1'b1;
        data  = d;
        took  = ready;
        @(posedge clk);
    endtask

    task automatic releaseValid();
        @(negedge clk);
        valid = 1'b0;
        data  = 8'hEE;
    endtask

    task automatic sendByte(input logic [7:0] d);
        logic took;
        int   tries;
        took  = 1'b0;
        tries = 0;
        while (!took && tries < 500) begin
            applyStimulus(d, took);
            tries++;
        end
        if (!took) checkOutput("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle(input int bound, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < bound);
        checkOutput(name, busy, 0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] rxAt(input int i);
        if (i < rx_q.size()) return {24'h0, rx_q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int startAt(input int i);
        if (i < start_q.size()) return start_q[i];
        return -1000;
    endfunction

    initial begin
        logic       took;
        logic       exp_txd;
        logic       exp_busy;
        logic [9:0] got;
        int         base;
        int         sbase;
        int         cnt;
        logic       a5_seq [8];
        logic [7:0] bytes4 [4];
        logic [7:0] full_bytes [6];
        logic [7:0] bnd_bytes [6];

        vecs[0] = '{din: 8'h00, frame: 10'b1_00000000_0};
        vecs[1] = '{din: 8'hFF, frame: 10'b1_11111111_0};
        vecs[2] = '{din: 8'h55, frame: 10'b1_01010101_0};
        vecs[3] = '{din: 8'h81, frame: 10'b1_10000001_0};
        vecs[4] = '{din: 8'h3C, frame: 10'b1_00111100_0};
        vecs[5] = '{din: 8'hA5, frame: 10'b1_10100101_0};
        a5_seq  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bytes4     = '{8'h00, 8'hFF, 8'h55, 8'h81};
        full_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};
        bnd_bytes  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};

        $display("[TB] start");

        // Reset values in the first cycle after reset
        doReset();
        @(negedge clk);
        checkOutput("reset_txd", txd, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_ready", ready, 1);

        // Single byte 0xA5, cycle-accurate line and busy profile
        base = rx_q.size();
        applyStimulus(8'hA5, took);
        checkOutput("a5_accept", took, 1);
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            if (c == 0) begin
                valid = 1'b0;
                data  = 8'hEE;
            end
            exp_txd = 1'b1;
            if (c >= 2 && c < 6) exp_txd = 1'b0;
            else if (c >= 6 && c < 38) exp_txd = a5_seq[(c - 6) / 4];
            exp_busy = (c < 42);
            checkOutput($sformatf("a5_txd_c%0d", c), txd, exp_txd);
            checkOutput($sformatf("a5_busy_c%0d", c), busy, exp_busy);
        end
        checkOutput("a5_decoded", rxAt(base), 32'hA5);

        // Table-driven single frames sampled at bit centres
        for (int v = 0; v < 6; v++) begin
            base = rx_q.size();
            got  = '0;
            applyStimulus(vecs[v].din, took);
            checkOutput($sformatf("vec%0d_accept", v), took, 1);
            for (int c = 0; c < 46; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    valid = 1'b0;
                    data  = 8'hEE;
                end
                if (c >= 4 && c < 44 && ((c - 4) % 4) == 0) got[(c - 4) / 4] = txd;
            end
            checkOutput($sformatf("vec%0d_frame", v), {22'h0, got}, {22'h0, vecs[v].frame});
            checkOutput($sformatf("vec%0d_idle", v), busy, 0);
            checkOutput($sformatf("vec%0d_decoded", v), rxAt(base), {24'h0, vecs[v].din});
        end

        // Four bytes back-to-back: contiguous frames, 160 cycles start to last stop end
        base  = rx_q.size();
        sbase = start_q.size();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bytes4[i], took);
            checkOutput($sformatf("b2b_accept%0d", i), took, 1);
        end
        releaseValid();
        waitIdle(400, "b2b_idle");
        checkOutput("b2b_count", rx_q.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("b2b_byte%0d", i), rxAt(base + i), {24'h0, bytes4[i]});
        end
        for (int i = 1; i < 4; i++) begin
            checkOutput($sformatf("b2b_gap%0d", i), startAt(sbase + i) - startAt(sbase + i - 1), 40);
        end
        checkOutput("b2b_span", startAt(sbase + 3) + 40 - startAt(sbase), 160);
        checkOutput("b2b_framing", frame_err, 0);

        // FIFO full: valid held high is ignored, ready returns after a pop
        base = rx_q.size();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(full_bytes[i], took);
            checkOutput($sformatf("full_accept%0d", i), took, 1);
        end
        @(negedge clk);
        checkOutput("full_ready_low", ready, 0);
        checkOutput("full_busy", busy, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h66, took);
            if (took) cnt++;
        end
        checkOutput("full_ignored", cnt, 0);
        releaseValid();
        cnt = 0;
        while (!ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("full_ready_back", ready, 1);
        sendByte(8'h77);
        releaseValid();
        waitIdle(600, "full_idle");
        checkOutput("full_count", rx_q.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("full_byte%0d", i), rxAt(base + i), {24'h0, full_bytes[i]});
        end

        // Push and pop together at the stop-to-start boundary with three queued
        base  = rx_q.size();
        sbase = start_q.size();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bnd_bytes[i], took);
        end
        @(negedge clk);
        valid = 1'b0;
        data  = 8'hEE;
        repeat (36) @(negedge clk);
        checkOutput("bnd_ready_before", ready, 1);
        applyStimulus(bnd_bytes[4], took);
        checkOutput("bnd_push_at_boundary", took, 1);
        applyStimulus(bnd_bytes[5], took);
        checkOutput("bnd_ready_after", took, 1);
        @(negedge clk);
        valid = 1'b0;
        data  = 8'hEE;
        checkOutput("bnd_occupancy_full", ready, 0);
        waitIdle(800, "bnd_idle");
        checkOutput("bnd_count", rx_q.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("bnd_byte%0d", i), rxAt(base + i), {24'h0, bnd_bytes[i]});
        end
        checkOutput("bnd_gap", startAt(sbase + 1) - startAt(sbase), 40);

        // Reset mid-frame aborts the frame and drops the queued byte
        base = rx_q.size();
        applyStimulus(8'h3C, took);
        applyStimulus(8'h99, took);
        @(negedge clk);
        valid = 1'b0;
        data  = 8'hEE;
        repeat (13) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_txd", txd, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ready", ready, 1);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) cnt++;
        end
        checkOutput("abort_line_quiet", cnt, 0);
        checkOutput("abort_nothing_decoded", rx_q.size() - base, 0);
        sendByte(8'hC3);
        releaseValid();
        waitIdle(200, "abort_idle");
        checkOutput("abort_next_count", rx_q.size() - base, 1);
        checkOutput("abort_next_byte", rxAt(base), 32'hC3);

        // Loopback of all 256 byte values through the receiver model
        base = rx_q.size();
        cnt  = frame_err;
        for (int i = 0; i < 256; i++) begin
            sendByte(8'(i));
        end
        releaseValid();
        waitIdle(2000, "loop_idle");
        checkOutput("loop_count", rx_q.size() - base, 256);
        for (int i = 0; i < 256; i++) begin
            checkOutput($sformatf("loop_byte%0d", i), rxAt(base + i), i);
        end
        checkOutput("loop_framing", frame_err - cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
